// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA constants, colour type and pattern sequencer states
package vga_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int V_VISIBLE_DEF = 480;
  localparam int RGB_W         = 4;

  typedef struct packed {
    logic [RGB_W-1:0] r;
    logic [RGB_W-1:0] g;
    logic [RGB_W-1:0] b;
  } rgb12_t;

  typedef enum logic [1:0] {
    SHOW    = 2'd0,
    PENDING = 2'd1,
    BLANK   = 2'd2
  } state_t;

endpackage

// File: rtl/vga_frame_tick.sv
// rtl/vga_frame_tick.sv - frame boundary strobe and visible-area flag from scan position
module vga_frame_tick #(
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480
) (
  input  logic [10:0] row,
  input  logic [10:0] col,
  output logic        frame_tick,
  output logic        in_visible
);

  localparam logic [10:0] H_VIS = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS = 11'(V_VISIBLE);

  // First pixel of vertical blanking: seen exactly once per frame.
  assign frame_tick = (row == V_VIS) && (col == 11'd0);
  assign in_visible = (row < V_VIS) && (col < H_VIS);

endmodule

// File: rtl/vga_pattern_sequencer.sv
// rtl/vga_pattern_sequencer.sv - selects one of several pattern sources per frame,
// advancing on a timer or button press with a black frame between patterns.
module vga_pattern_sequencer
  import vga_pkg::*;
#(
  parameter int NUM_PATTERNS       = 4,
  parameter int SEL_W              = 2,
  parameter int FRAMES_PER_PATTERN = 120,
  parameter int FRAME_CNT_W        = 8,
  parameter int H_VISIBLE          = H_VISIBLE_DEF,
  parameter int V_VISIBLE          = V_VISIBLE_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [10:0]               row,
  input  logic [10:0]               col,
  input  logic                      auto_mode,
  input  logic                      next_btn,
  input  logic [12*NUM_PATTERNS-1:0] pat_rgb_in,
  output logic [RGB_W-1:0]          red,
  output logic [RGB_W-1:0]          green,
  output logic [RGB_W-1:0]          blue,
  output logic [SEL_W-1:0]          pattern_sel,
  output logic                      switch_pulse
);

  localparam logic [SEL_W-1:0]       SEL_LAST = SEL_W'(NUM_PATTERNS - 1);
  localparam logic [FRAME_CNT_W-1:0] CNT_LAST = FRAME_CNT_W'(FRAMES_PER_PATTERN - 1);

  logic frame_tick;
  logic in_visible;

  vga_frame_tick #(
    .H_VISIBLE (H_VISIBLE),
    .V_VISIBLE (V_VISIBLE)
  ) u_frame_tick (
    .row        (row),
    .col        (col),
    .frame_tick (frame_tick),
    .in_visible (in_visible)
  );

  state_t                 state_q, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d, sel_adv;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
  logic                   pulse_q, pulse_d;
  logic                   next_btn_q;
  logic                   press;
  rgb12_t                 rgb_q, rgb_d, pix;

  assign press   = next_btn & ~next_btn_q;
  assign sel_adv = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;

  always_comb begin : fsm_next
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      SHOW: begin
        // A press outranks a coinciding timer expiry so only one advance occurs.
        if (press) begin
          state_d = PENDING;
          cnt_d   = '0;
        end else if (!auto_mode) begin
          cnt_d = '0;
        end else if (frame_tick) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            sel_d   = sel_adv;
            pulse_d = 1'b1;
            state_d = BLANK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PENDING: begin
        cnt_d = '0;
        if (frame_tick) begin
          sel_d   = sel_adv;
          pulse_d = 1'b1;
          state_d = BLANK;
        end
      end
      BLANK: begin
        cnt_d = '0;
        if (frame_tick) state_d = SHOW;
      end
      default: state_d = SHOW;
    endcase
  end

  always_comb begin : pix_mux
    pix = '0;
    for (int k = 0; k < NUM_PATTERNS; k++) begin
      if (sel_q == SEL_W'(k)) pix = pat_rgb_in[12*k +: 12];
    end
  end

  assign rgb_d = (state_q == BLANK || !in_visible) ? '0 : pix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SHOW;
      sel_q      <= '0;
      cnt_q      <= '0;
      pulse_q    <= 1'b0;
      next_btn_q <= 1'b0;
      rgb_q      <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      pulse_q    <= pulse_d;
      next_btn_q <= next_btn;
      rgb_q      <= rgb_d;
    end
  end

  assign red          = rgb_q.r;
  assign green        = rgb_q.g;
  assign blue         = rgb_q.b;
  assign pattern_sel  = sel_q;
  assign switch_pulse = pulse_q;

endmodule

// File: doc/vga_pattern_sequencer.md
Name: vga_pattern_sequencer

Overview:
- Controller that time-shares the VGA RGB output among NUM_PATTERNS pattern generators (colour stripes, checkerboard, etc.), all driven from the same row/col.
- Selects one generator and advances the selection either automatically every FRAMES_PER_PATTERN frames or on a user "next" request.
- Selection changes only at a frame boundary, with one full black frame inserted between patterns.
- Sits between the pattern generators and the VGA sync/output stage.

Parameters:
- NUM_PATTERNS, 4, number of pattern sources (2..16).
- SEL_W, 2, width of pattern_sel; must satisfy 2**SEL_W >= NUM_PATTERNS.
- FRAMES_PER_PATTERN, 120, frames each pattern is shown in auto mode (>=1).
- FRAME_CNT_W, 8, frame counter width; must hold FRAMES_PER_PATTERN-1.
- H_VISIBLE, 640, visible columns.
- V_VISIBLE, 480, visible rows.

Ports:
- clk  input  1  pixel clock.
- rst  input  1  reset, asynchronous, active-high.
- row  input  11  current scan row from the timing generator.
- col  input  11  current scan column from the timing generator.
- auto_mode  input  1  1 = timed auto-advance; 0 = manual only.
- next_btn  input  1  synchronised, debounced level; each rising edge is one request.
- pat_rgb_in  input  12*NUM_PATTERNS  packed source colours; pattern k occupies bits [12k+11:12k] as {red[3:0],green[3:0],blue[3:0]}.
- red  output  4  registered red.
- green  output  4  registered green.
- blue  output  4  registered blue.
- pattern_sel  output  SEL_W  index of the current/next pattern.
- switch_pulse  output  1  one-cycle pulse on the cycle pattern_sel changes.

Behaviour:
Reset:
- All of the following reset asynchronously: state=SHOW, pattern_sel=0, frame_cnt=0, red/green/blue=0, switch_pulse=0, next_btn_d=0.

Frame tick:
- frame_tick is combinational: row==V_VISIBLE && col==0, i.e. the first pixel of vertical blanking.
- It is true for exactly one cycle per frame.

Request:
- press = next_btn & ~next_btn_d, where next_btn_d is a registered copy of next_btn.

State machine:
- SHOW:
  - If press, go to PENDING and clear frame_cnt.
  - Else, if auto_mode and frame_tick:
    - when frame_cnt == FRAMES_PER_PATTERN-1: clear frame_cnt, advance pattern_sel, pulse switch_pulse, go to BLANK;
    - otherwise: frame_cnt += 1.
  - If press and auto expiry fall on the same cycle, press takes priority, so only one advance happens (at the next frame_tick).
- PENDING:
  - On frame_tick: advance pattern_sel, pulse switch_pulse, go to BLANK.
- BLANK:
  - Output black for the whole frame.
  - On the next frame_tick go to SHOW; frame_cnt restarts from 0.
- Presses in PENDING or BLANK are ignored (dropped, not queued).

Advance and counter rules:
- Advance: pattern_sel = (pattern_sel == NUM_PATTERNS-1) ? 0 : pattern_sel+1.
- auto_mode==0 holds frame_cnt at 0.
- Toggling auto_mode mid-frame takes effect on the next cycle; no pending state is lost.

Colour output:
- RGB next-value:
  - black if state==BLANK, col>=H_VISIBLE, or row>=V_VISIBLE;
  - else the pat_rgb_in slice selected by pattern_sel.
- RGB is registered, so latency is 1 clk from row/col/pat_rgb_in to red/green/blue.
- The source generators add their own 1-clk register; the downstream stage aligns sync by 2.
- Unused selects (>= NUM_PATTERNS) are unreachable; the mux default is black.

Reset during operation:
- Outputs go to 0 immediately.
- The sequence restarts from pattern 0 in SHOW after release.

Decomposition:
- Package vga_pkg: H_VISIBLE/V_VISIBLE defaults, RGB_W=4, a packed rgb12 typedef, and the state enum {SHOW, PENDING, BLANK}.
- Sub-module vga_frame_tick: row/col compare that produces frame_tick plus an in_visible flag. It is reused by other VGA blocks.
- Mux, counter and FSM stay in the top module.

Test Plan:
1. Reset mid-frame with pat0=12'hF00 -> after release, in visible area red=F, green=0, blue=0 one clk after col valid; pattern_sel=0; switch_pulse=0.
2. auto_mode=1, FRAMES_PER_PATTERN=3, NUM_PATTERNS=3 -> pattern_sel goes 0→1 at the 3rd frame_tick, then the frame is all black, then pattern 1 is shown; the sequence 0,1,2,0 wraps; switch_pulse is exactly 1 clk each time.
3. auto_mode=0, next_btn held high for 5000 clks mid-frame -> one advance only, taken at the next frame_tick, followed by one black frame; no change without a press.
4. Press on the same cycle as auto expiry -> single advance (0→1), never 0→2.
5. Press during BLANK -> ignored; pattern_sel unchanged after BLANK ends.
6. col=640..799 or row=480..524 in SHOW -> RGB=000 regardless of pat_rgb_in.
